// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit driving a req/gnt/rvalid data port and the MEM/WB beat
module mem_stage_lsu #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid_i,
    input  logic [XLEN-1:0]   ex_result_i,
    input  logic [XLEN-1:0]   ex_store_data_i,
    input  logic              ex_is_load_i,
    input  logic              ex_is_store_i,
    input  logic [1:0]        ex_size_i,
    input  logic              ex_unsigned_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              ex_wb_en_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [XLEN-1:0]   dmem_addr_o,
    output logic [3:0]        dmem_be_o,
    output logic [XLEN-1:0]   dmem_wdata_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [XLEN-1:0]   dmem_rdata_i,
    output logic              stall_o,
    output logic              misaligned_o,
    output logic              wb_valid_o,
    output logic              wb_en_o,
    output logic [REG_AW-1:0] wb_rd_o,
    output logic [XLEN-1:0]   wb_data_o
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    state_t state, state_nx;
    logic [1:0] a, lat_off, lat_size;
    logic lat_uns, lat_wb_en, mem_op, aligned;
    logic [REG_AW-1:0] lat_rd;
    logic [3:0] be_nx;
    logic [XLEN-1:0] wdata_nx, sh, ld_data;
    assign a = ex_result_i[1:0];
    assign mem_op = ex_valid_i && (ex_is_load_i || ex_is_store_i);
    assign aligned = ex_size_i == 2'b00 || (ex_size_i == 2'b01 && !a[0]) || (ex_size_i == 2'b10 && a == 2'b00);
    assign be_nx = ex_size_i == 2'b00 ? 4'b0001 << a : ex_size_i == 2'b01 ? 4'b0011 << {a[1], 1'b0} : 4'b1111;
    assign wdata_nx = !ex_is_store_i ? '0 :
                      ex_size_i == 2'b00 ? {4{ex_store_data_i[7:0]}} :
                      ex_size_i == 2'b01 ? {2{ex_store_data_i[15:0]}} : ex_store_data_i;
    assign sh = dmem_rdata_i >> {lat_off, 3'b000};
    assign ld_data = lat_size == 2'b00 ? {{24{!lat_uns && sh[7]}}, sh[7:0]} :
                     lat_size == 2'b01 ? {{16{!lat_uns && sh[15]}}, sh[15:0]} : sh;
    assign stall_o = state != IDLE;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        if (state == IDLE && mem_op && aligned) state_nx = REQ;
        else if (state == REQ && dmem_gnt_i) state_nx = dmem_we_o ? IDLE : WAIT;
        else if (state == WAIT && dmem_rvalid_i) state_nx = IDLE;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_be_o    <= '0;
            dmem_wdata_o <= '0;
            misaligned_o <= 1'b0;
            wb_valid_o   <= 1'b0;
            wb_en_o      <= 1'b0;
            wb_rd_o      <= '0;
            wb_data_o    <= '0;
            lat_off      <= '0;
            lat_size     <= '0;
            lat_uns      <= 1'b0;
            lat_rd       <= '0;
            lat_wb_en    <= 1'b0;
        end else begin
            wb_valid_o   <= 1'b0;
            misaligned_o <= 1'b0;
            if (state == IDLE && ex_valid_i) begin
                if (!ex_is_load_i && !ex_is_store_i) begin
                    wb_valid_o <= 1'b1;
                    wb_en_o    <= ex_wb_en_i;
                    wb_rd_o    <= ex_rd_i;
                    wb_data_o  <= ex_result_i;
                end else if (!aligned) begin
                    misaligned_o <= 1'b1;
                end else begin
                    dmem_req_o   <= 1'b1;
                    dmem_we_o    <= ex_is_store_i;
                    dmem_addr_o  <= {ex_result_i[XLEN-1:2], 2'b00};
                    dmem_be_o    <= be_nx;
                    dmem_wdata_o <= wdata_nx;
                    lat_off      <= a;
                    lat_size     <= ex_size_i;
                    lat_uns      <= ex_unsigned_i;
                    lat_rd       <= ex_rd_i;
                    lat_wb_en    <= ex_wb_en_i;
                end
            end
            if (state == REQ && dmem_gnt_i) begin
                dmem_req_o <= 1'b0;
                if (dmem_we_o) begin
                    wb_valid_o <= 1'b1;
                    wb_en_o    <= 1'b0;
                    wb_rd_o    <= lat_rd;
                end
            end
            if (state == WAIT && dmem_rvalid_i) begin
                wb_valid_o <= 1'b1;
                wb_en_o    <= lat_wb_en;
                wb_rd_o    <= lat_rd;
                wb_data_o  <= ld_data;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: random and directed instruction stream checked against a transaction-level model
module tb_mem_stage_lsu;
    logic clk = 1'b0, reset = 1'b1;
    logic ex_valid = 1'b0, ex_is_load = 1'b0, ex_is_store = 1'b0, ex_unsigned = 1'b0, ex_wb_en = 1'b0;
    logic [31:0] ex_result = '0, ex_store_data = '0, rdata = '0;
    logic [1:0] ex_size = '0;
    logic [4:0] ex_rd = '0;
    logic gnt = 1'b0, rvalid = 1'b0;
    logic dmem_req, dmem_we, stall, misaligned, wb_valid, wb_en;
    logic [31:0] dmem_addr, dmem_wdata, wb_data;
    logic [3:0] dmem_be;
    logic [4:0] wb_rd;
    int checks = 0, errors = 0;
    logic chk_en = 1'b0;
    logic e_stall = 0, e_req = 0, e_we = 0, e_wbv = 0, e_wben = 0, e_store = 0, e_mis = 0;
    logic [31:0] e_addr = '0, e_wdata = '0, e_data = '0;
    logic [3:0] e_be = '0;
    logic [4:0] e_rd = '0;
    int obs_req = 0, obs_stall = 0, obs_wbv = 0, obs_mis = 0;
    logic [31:0] obs_addr = '0, obs_wdata = '0;
    logic [3:0] obs_be = '0;

    mem_stage_lsu dut (
        .clk(clk), .reset(reset),
        .ex_valid_i(ex_valid), .ex_result_i(ex_result), .ex_store_data_i(ex_store_data),
        .ex_is_load_i(ex_is_load), .ex_is_store_i(ex_is_store), .ex_size_i(ex_size),
        .ex_unsigned_i(ex_unsigned), .ex_rd_i(ex_rd), .ex_wb_en_i(ex_wb_en),
        .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr), .dmem_be_o(dmem_be),
        .dmem_wdata_o(dmem_wdata), .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata),
        .stall_o(stall), .misaligned_o(misaligned), .wb_valid_o(wb_valid), .wb_en_o(wb_en),
        .wb_rd_o(wb_rd), .wb_data_o(wb_data)
    );

    initial forever #5 clk = ~clk;
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", 32'(stall), 32'(e_stall));
            chk("req", 32'(dmem_req), 32'(e_req));
            chk("wb_valid", 32'(wb_valid), 32'(e_wbv));
            chk("misaligned", 32'(misaligned), 32'(e_mis));
            if (e_req) begin
                chk("we", 32'(dmem_we), 32'(e_we));
                chk("addr", dmem_addr, e_addr);
                chk("be", 32'(dmem_be), 32'(e_be));
                chk("wdata", dmem_wdata, e_wdata);
            end
            if (e_wbv) begin
                chk("wb_en", 32'(wb_en), 32'(e_wben));
                if (!e_store) begin
                    chk("wb_rd", 32'(wb_rd), 32'(e_rd));
                    chk("wb_data", wb_data, e_data);
                end
            end
        end
        if (dmem_req) begin
            obs_req++;
            obs_addr = dmem_addr;
            obs_be = dmem_be;
            obs_wdata = dmem_wdata;
        end
        if (stall) obs_stall++;
        if (wb_valid) obs_wbv++;
        if (misaligned) obs_mis++;
    end

    task automatic obs_clear();
        obs_req = 0; obs_stall = 0; obs_wbv = 0; obs_mis = 0;
    endtask

    // One instruction through the stage; gd = extra grant wait cycles, rdl = extra rvalid wait cycles.
    task automatic op(input logic v, input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                      input logic [31:0] res, input logic [31:0] sd, input logic [4:0] rd, input logic wen,
                      input int gd, input int rdl, input logic [31:0] word);
        int n, off, lat;
        logic mem, mis;
        logic [3:0] be4;
        logic [31:0] wd, ldv;
        ex_valid = v; ex_is_load = ld; ex_is_store = st; ex_size = sz; ex_unsigned = uns;
        ex_result = res; ex_store_data = sd; ex_rd = rd; ex_wb_en = wen;
        gnt = 1'($urandom_range(0, 1));
        rvalid = 1'($urandom_range(0, 1));
        rdata = $urandom;
        n = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
        off = int'(res[1:0]);
        mem = v && (ld || st);
        mis = mem && (sz == 2'd3 || off % n != 0);
        lat = (!mem || mis) ? 1 : st ? 2 + gd : 3 + gd + rdl;
        be4 = '0;
        wd = '0;
        ldv = '0;
        if (!mis) begin
            for (int i = 0; i < n; i++) be4[off + i] = 1'b1;
            for (int j = 0; j < 4; j++) wd[8*j +: 8] = sd[8*(j % n) +: 8];
            for (int i = 0; i < n; i++) ldv[8*i +: 8] = word[8*(off + i) +: 8];
        end
        if (!uns && n < 4 && ldv[8*n-1]) ldv = ldv - (32'd1 << (8 * n));
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk);
            #1;
            if (k < lat) begin
                ex_valid = 1'($urandom_range(0, 1)); ex_is_load = 1'($urandom_range(0, 1));
                ex_is_store = 1'($urandom_range(0, 1)); ex_size = 2'($urandom_range(0, 3));
                ex_result = $urandom; ex_store_data = $urandom; ex_rd = 5'($urandom_range(0, 31));
            end
            e_mis = mis && k == 1;
            e_stall = mem && !mis && k < lat;
            e_req = mem && !mis && k <= 1 + gd;
            e_we = st;
            e_addr = res & 32'hFFFF_FFFC;
            e_be = be4;
            e_wdata = st ? wd : 32'h0;
            e_wbv = v && !mis && k == lat;
            e_store = st;
            e_wben = st ? 1'b0 : wen;
            e_rd = rd;
            e_data = ld ? ldv : res;
            gnt = 1'b0;
            rvalid = 1'b0;
            if (mem && !mis) begin
                if (k <= 1 + gd) begin
                    gnt = k == 1 + gd;
                    rvalid = 1'($urandom_range(0, 1));
                    rdata = $urandom;
                end else if (ld && k < 2 + gd + rdl) begin
                    gnt = 1'($urandom_range(0, 1));
                end else if (ld && k == 2 + gd + rdl) begin
                    rvalid = 1'b1;
                    rdata = word;
                    gnt = 1'($urandom_range(0, 1));
                end
            end
        end
    endtask

    task automatic pin_sync();
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] sz;
        logic [31:0] res;
        int kind;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_stall", 32'(stall), 0);
        chk("rst_req", 32'(dmem_req), 0);
        chk("rst_we", 32'(dmem_we), 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_be", 32'(dmem_be), 0);
        chk("rst_wdata", dmem_wdata, 0);
        chk("rst_wb", {wb_valid, wb_en, misaligned}, 0);
        chk("rst_wb_rd", 32'(wb_rd), 0);
        chk("rst_wb_data", wb_data, 0);
        @(posedge clk);
        #1;
        chk_en = 1'b1;

        obs_clear();
        op(1, 0, 0, 2'd2, 0, 32'h1234_5678, 32'h0, 5'd5, 1, 0, 0, 32'h0);
        pin_sync();
        chk("alu_data", wb_data, 32'h1234_5678);
        chk("alu_rd", 32'(wb_rd), 5);
        chk("alu_stall_cycles", obs_stall, 0);

        obs_clear();
        op(1, 0, 1, 2'd0, 0, 32'h0000_0103, 32'hAABB_CCDD, 5'd7, 0, 0, 0, 32'h0);
        pin_sync();
        chk("sb_req_cycles", obs_req, 1);
        chk("sb_addr", obs_addr, 32'h0000_0100);
        chk("sb_be", 32'(obs_be), 32'b1000);
        chk("sb_wdata", obs_wdata, 32'hDDDD_DDDD);
        chk("sb_wb_beats", obs_wbv, 1);

        op(1, 1, 0, 2'd0, 0, 32'h0000_0101, 32'h0, 5'd3, 1, 2, 1, 32'h0000_8000);
        pin_sync();
        chk("lb_data", wb_data, 32'hFFFF_FF80);
        op(1, 1, 0, 2'd0, 1, 32'h0000_0101, 32'h0, 5'd3, 1, 2, 1, 32'h0000_8000);
        pin_sync();
        chk("lbu_data", wb_data, 32'h0000_0080);

        obs_clear();
        op(1, 1, 0, 2'd1, 0, 32'h0000_0203, 32'h0, 5'd9, 1, 0, 0, 32'h0);
        pin_sync();
        chk("lh_mis_pulse", obs_mis, 1);
        chk("lh_mis_req", obs_req, 0);
        chk("lh_mis_wb", obs_wbv + obs_stall, 0);
        obs_clear();
        op(1, 1, 0, 2'd2, 0, 32'h0000_0202, 32'h0, 5'd9, 1, 0, 0, 32'h0);
        pin_sync();
        chk("lw_mis_pulse", obs_mis, 1);
        chk("lw_mis_req", obs_req + obs_wbv + obs_stall, 0);

        obs_clear();
        op(1, 1, 0, 2'd2, 0, 32'h0000_0040, 32'h0, 5'd12, 1, 3, 0, 32'hCAFE_F00D);
        pin_sync();
        chk("lw_req_cycles", obs_req, 4);
        chk("lw_stall_cycles", obs_stall, 5);
        chk("lw_data", wb_data, 32'hCAFE_F00D);

        for (int t = 0; t < 400; t++) begin
            kind = $urandom_range(0, 9);
            sz = $urandom_range(0, 11) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
            res = $urandom;
            if ($urandom_range(0, 1) == 1) res[1:0] = sz == 2'd2 ? 2'b00 : sz == 2'd1 ? {res[1], 1'b0} : res[1:0];
            op(kind != 0, kind >= 4 && kind <= 6, kind >= 7, sz, 1'($urandom_range(0, 1)), res, $urandom,
               5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end

        ex_valid = 1'b0; gnt = 1'b0; rvalid = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1'b0;
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_is_store = 1'b0; ex_size = 2'd2; ex_result = 32'h80; ex_rd = 5'd4; ex_wb_en = 1'b1;
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        gnt = 1'b1;
        @(posedge clk);
        #1;
        gnt = 1'b0;
        chk("pre_rst_wait_stall", 32'(stall), 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_stall", 32'(stall), 0);
        chk("mid_rst_req", 32'(dmem_req), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        rvalid = 1'b1;
        rdata = 32'h1357_9BDF;
        @(posedge clk);
        #1;
        rvalid = 1'b0;
        @(negedge clk);
        chk("post_rst_wb_valid", 32'(wb_valid), 0);
        chk("post_rst_stall", 32'(stall), 0);
        chk("post_rst_req_addr", {dmem_req, dmem_we, dmem_be} | dmem_addr | dmem_wdata, 0);
        chk("post_rst_wb", {wb_en, misaligned, wb_rd} | wb_data, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
